uart_loader: RTL

Serial boot/debug loader that acts as a bus master on the UART register interface. It polls the UART for received bytes, parses framed load/jump packets, and writes payload data to system memory as 32-bit words. Its `o_jump_*` outputs release the CPU at a new entry point. It sits between the UART and the memory interconnect, and is active while the CPU is held in reset or during debug.

---
 rtl/uart_loader.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_loader.sv
// uart_loader: UART-polling boot loader. Parses SYNC-framed LOAD/JUMP
// packets and writes the payload to memory as byte-masked 32-bit words.
// Ports: i_clock, i_reset (async, active-low), i_enable (run/idle);
//   o_uart_request/rw/address, i_uart_rdata/ready: read-only UART master
//     (address 1 = status, bit0 = rx available; address 0 = rx pop);
//   o_mem_request/rw/address/wdata/wmask, i_mem_ready: word write master;
//   o_busy, o_done (pulse), o_error (sticky until next SYNC);
//   o_jump_valid (pulse), o_jump_address (held): CPU release.
// Build option: define UART_LOADER_CHECKSUM_EN for a trailing sum byte.
module uart_loader #(
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter logic [15:0] MAX_LENGTH = 16'd65535
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_enable,
    output logic        o_uart_request,
    output logic        o_uart_rw,
    output logic [1:0]  o_uart_address,
    input  logic [31:0] i_uart_rdata,
    input  logic        i_uart_ready,
    output logic        o_mem_request,
    output logic        o_mem_rw,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wmask,
    input  logic        i_mem_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic        o_jump_valid,
    output logic [31:0] o_jump_address
);

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_JUMP = 8'h02;

    typedef enum logic [1:0] {F_STATUS, F_DATA, F_WRITE} fetch_t;
`ifdef UART_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        P_SYNC, P_CMD, P_ADDR, P_LEN, P_DATA, P_SUM
    } parse_t;
    localparam parse_t P_END = P_SUM;
`else
    typedef enum logic [2:0] {
        P_SYNC, P_CMD, P_ADDR, P_LEN, P_DATA
    } parse_t;
    localparam parse_t P_END = P_SYNC;
`endif

    fetch_t f_state, f_next;
    parse_t p_state, p_next;

    logic [31:0] ld_addr;
    logic [29:0] waddr;
    logic [7:0]  len_lo;
    logic [15:0] remain;
    logic [31:0] wbuf;
    logic [3:0]  wmask;
    logic [1:0]  lane;
    logic [1:0]  cnt;
    logic        is_jump;
    logic        mem_rw_q;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]  sum;
`endif

    logic        uart_done, mem_done, byte_valid, uart_issue;
    logic [7:0]  rx;
    logic [15:0] len_full;
    logic [31:0] buf_next;
    logic [3:0]  mask_next;
    logic        last, flush, bad_cmd, bad_len, abort;
    logic        frame_end, jump_end, done_set;
    logic        unused_rdata;

    assign rx           = i_uart_rdata[7:0];
    assign unused_rdata = ^i_uart_rdata[31:8];
    assign uart_done    = o_uart_request & i_uart_ready;
    assign mem_done     = o_mem_request & i_mem_ready;
    assign byte_valid   = uart_done & (f_state == F_DATA);
    // Only raising from an idle request guarantees one idle cycle
    // between consecutive UART cycles.
    assign uart_issue   = i_enable & ~o_uart_request
                        & (f_state != F_WRITE);
    assign len_full     = {rx, len_lo};
    assign last         = (remain == 16'd1);
    assign flush        = byte_valid & (p_state == P_DATA)
                        & ((lane == 2'd3) | last);
    assign bad_cmd      = (p_state == P_CMD) & (rx != CMD_LOAD)
                        & (rx != CMD_JUMP);
    assign bad_len      = (p_state == P_LEN) & (cnt == 2'd1)
                        & (len_full > MAX_LENGTH);
    assign abort        = byte_valid & (bad_cmd | bad_len);
    assign frame_end    = byte_valid & (p_state != P_SYNC)
                        & (p_next == P_SYNC);
    assign jump_end     = byte_valid & (p_state == P_ADDR)
                        & (cnt == 2'd3) & is_jump;
    assign done_set     = frame_end & ~abort;
    assign o_uart_rw    = 1'b0;
    // Write-only master; low only while in reset.
    assign o_mem_rw     = mem_rw_q;

    always_comb begin
        buf_next = wbuf;
        buf_next[{lane, 3'b000} +: 8] = rx;
        mask_next = wmask | (4'b0001 << lane);
    end

    always_comb begin
        f_next = f_state;
        unique case (f_state)
            F_STATUS: if (uart_done && i_uart_rdata[0]) f_next = F_DATA;
            F_DATA:   if (uart_done) f_next = flush ? F_WRITE : F_STATUS;
            F_WRITE:  if (mem_done) f_next = F_STATUS;
            default:  f_next = F_STATUS;
        endcase
    end

    always_comb begin
        p_next = p_state;
        if (byte_valid) begin
            unique case (p_state)
                P_SYNC: if (rx == SYNC_BYTE) p_next = P_CMD;
                P_CMD:  p_next = bad_cmd ? P_SYNC : P_ADDR;
                P_ADDR: if (cnt == 2'd3) p_next = is_jump ? P_SYNC : P_LEN;
                P_LEN: begin
                    if (cnt == 2'd1) begin
                        if (bad_len)                 p_next = P_SYNC;
                        else if (len_full == 16'd0)  p_next = P_END;
                        else                         p_next = P_DATA;
                    end
                end
                P_DATA: if (last) p_next = P_END;
`ifdef UART_LOADER_CHECKSUM_EN
                P_SUM:  p_next = P_SYNC;
`endif
                default: p_next = P_SYNC;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            f_state <= F_STATUS;
            p_state <= P_SYNC;
        end else begin
            f_state <= f_next;
            p_state <= p_next;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_uart_request <= 1'b0;
            o_uart_address <= 2'd0;
        end else if (uart_done) begin
            o_uart_request <= 1'b0;
        end else if (uart_issue) begin
            o_uart_request <= 1'b1;
            o_uart_address <= (f_state == F_STATUS) ? 2'd1 : 2'd0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            ld_addr        <= '0;
            waddr          <= '0;
            len_lo         <= '0;
            remain         <= '0;
            wbuf           <= '0;
            wmask          <= '0;
            lane           <= '0;
            cnt            <= '0;
            is_jump        <= 1'b0;
            mem_rw_q       <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            sum            <= '0;
`endif
            o_mem_request  <= 1'b0;
            o_mem_address  <= '0;
            o_mem_wdata    <= '0;
            o_mem_wmask    <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
            o_jump_valid   <= 1'b0;
            o_jump_address <= '0;
        end else begin
            mem_rw_q     <= 1'b1;
            o_done       <= done_set;
            o_jump_valid <= jump_end;
            if (byte_valid) begin
                unique case (p_state)
                    P_SYNC: begin
                        if (rx == SYNC_BYTE) begin
                            o_error <= 1'b0;
                            o_busy  <= 1'b1;
                        end
                    end
                    P_CMD: begin
                        is_jump <= (rx == CMD_JUMP);
                        cnt     <= 2'd0;
                    end
                    P_ADDR: begin
                        ld_addr[{cnt, 3'b000} +: 8] <= rx;
                        cnt <= cnt + 2'd1;
                    end
                    P_LEN: begin
                        len_lo <= rx;
                        cnt    <= cnt + 2'd1;
                        remain <= len_full;
                        lane   <= ld_addr[1:0];
                        waddr  <= ld_addr[31:2];
                        wbuf   <= '0;
                        wmask  <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
                        sum    <= '0;
`endif
                    end
                    P_DATA: begin
                        remain <= remain - 16'd1;
                        lane   <= lane + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                        sum    <= sum + rx;
`endif
                        if (flush) begin
                            wbuf  <= '0;
                            wmask <= '0;
                            waddr <= waddr + 30'd1;
                        end else begin
                            wbuf  <= buf_next;
                            wmask <= mask_next;
                        end
                    end
`ifdef UART_LOADER_CHECKSUM_EN
                    P_SUM: if (rx != sum) o_error <= 1'b1;
`endif
                    default: ;
                endcase
                if (abort)     o_error <= 1'b1;
                if (frame_end) o_busy  <= 1'b0;
            end
            if (jump_end) o_jump_address <= {rx, ld_addr[23:0]};
            if (flush) begin
                o_mem_request <= 1'b1;
                o_mem_address <= {waddr, 2'b00};
                o_mem_wdata   <= buf_next;
                o_mem_wmask   <= mask_next;
            end else if (mem_done) begin
                o_mem_request <= 1'b0;
            end
        end
    end

endmodule
